// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Front-panel sequencer for a switch/button driven ALU demo. The user loads
//   operand A, then operand B, then an opcode, using three debounced buttons.
//   The controller then lets the external combinational ALU settle for one
//   cycle, captures its result and overflow flag onto LEDs, and flags any
//   out-of-order press or unsupported opcode as a sticky error.
//
// Ports
//   i_clk          single clock, rising edge
//   i_reset        asynchronous, active-low reset
//   i_dataSw       operand switches (NB_DATA)
//   i_opSw         opcode switches (NB_OP)
//   i_btnA/B/O     debounced button levels: load A / load B / load op + execute
//   i_aluResult    combinational ALU result for o_dataA/o_dataB/o_op
//   i_aluOverflow  combinational ALU overflow flag
//   o_dataA/B      registered operands driving the ALU
//   o_op           registered opcode driving the ALU
//   o_resultLed    captured ALU result
//   o_overflowLed  captured ALU overflow
//   o_valid        captured result belongs to the current operands
//   o_error        sticky sequence/opcode error
//   o_state        FSM state: IDLE=0, HAVE_A=1, HAVE_B=2, EXEC=3, DONE=4
module alu_seq_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_dataSw,
  input  logic [NB_OP-1:0]   i_opSw,
  input  logic               i_btnA,
  input  logic               i_btnB,
  input  logic               i_btnO,
  input  logic [NB_DATA-1:0] i_aluResult,
  input  logic               i_aluOverflow,
  output logic [NB_DATA-1:0] o_dataA,
  output logic [NB_DATA-1:0] o_dataB,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_resultLed,
  output logic               o_overflowLed,
  output logic               o_valid,
  output logic               o_error,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HAVE_A = 3'd1,
    HAVE_B = 3'd2,
    EXEC   = 3'd3,
    DONE   = 3'd4
  } stateT;

  // Supported opcodes: ADD, SUB, AND, OR, XOR, NOR, SRA, SRL.
  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  // Button bit order inside the vectors below.
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_O = 2;

  logic [2:0]         btnLevel;
  logic [2:0]         btnSampleReg;
  logic [2:0]         btnPrevReg;
  logic [2:0]         btnEdge;
  logic               collision;
  logic               opSupported;

  stateT              stateReg, stateNext;
  logic [NB_DATA-1:0] dataAReg, dataANext;
  logic [NB_DATA-1:0] dataBReg, dataBNext;
  logic [NB_OP-1:0]   opReg, opNext;
  logic [NB_DATA-1:0] resultReg, resultNext;
  logic               overflowReg, overflowNext;
  logic               validReg, validNext;
  logic               errorReg, errorNext;

  assign btnLevel = {i_btnO, i_btnB, i_btnA};

  // Buttons are sampled once, then compared with the previous sample. Both
  // stages come out of reset at 1 so that a button already held down when
  // reset releases looks like "still pressed" and must be released and
  // pressed again before it counts.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      btnSampleReg <= 3'b111;
      btnPrevReg   <= 3'b111;
    end else begin
      btnSampleReg <= btnLevel;
      btnPrevReg   <= btnSampleReg;
    end
  end

  assign btnEdge   = btnSampleReg & ~btnPrevReg;
  assign collision = (btnEdge[BTN_A] & btnEdge[BTN_B]) |
                     (btnEdge[BTN_A] & btnEdge[BTN_O]) |
                     (btnEdge[BTN_B] & btnEdge[BTN_O]);

  always_comb begin
    opSupported = 1'b0;
    case (i_opSw)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: opSupported = 1'b1;
      default:                        opSupported = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stateReg    <= IDLE;
      dataAReg    <= '0;
      dataBReg    <= '0;
      opReg       <= '0;
      resultReg   <= '0;
      overflowReg <= 1'b0;
      validReg    <= 1'b0;
      errorReg    <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      dataAReg    <= dataANext;
      dataBReg    <= dataBNext;
      opReg       <= opNext;
      resultReg   <= resultNext;
      overflowReg <= overflowNext;
      validReg    <= validNext;
      errorReg    <= errorNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    dataANext    = dataAReg;
    dataBNext    = dataBReg;
    opNext       = opReg;
    resultNext   = resultReg;
    overflowNext = overflowReg;
    validNext    = validReg;
    errorNext    = errorReg;

    if (stateReg == EXEC) begin
      // The ALU has had a full cycle on the registered operands; capture it.
      // Any press arriving now is dropped silently, collisions included.
      resultNext   = i_aluResult;
      overflowNext = i_aluOverflow;
      validNext    = 1'b1;
      stateNext    = DONE;
    end else if (collision) begin
      errorNext = 1'b1;
    end else if (btnEdge[BTN_A]) begin
      // A restarts the sequence from anywhere; the LEDs keep the old result.
      dataANext = i_dataSw;
      validNext = 1'b0;
      errorNext = 1'b0;
      stateNext = HAVE_A;
    end else if (btnEdge[BTN_B]) begin
      if (stateReg == HAVE_A) begin
        dataBNext = i_dataSw;
        stateNext = HAVE_B;
      end else begin
        errorNext = 1'b1;
      end
    end else if (btnEdge[BTN_O]) begin
      if (stateReg == HAVE_B && opSupported) begin
        opNext    = i_opSw;
        stateNext = EXEC;
      end else begin
        errorNext = 1'b1;
      end
    end
  end

  assign o_dataA       = dataAReg;
  assign o_dataB       = dataBReg;
  assign o_op          = opReg;
  assign o_resultLed   = resultReg;
  assign o_overflowLed = overflowReg;
  assign o_valid       = validReg;
  assign o_error       = errorReg;
  assign o_state       = stateReg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl. Inputs change on the falling clock edge,
// outputs are checked on the falling edge (or a few ns after an asynchronous
// reset edge). A tiny behavioural ALU drives i_aluResult/i_aluOverflow.
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rstN;
  logic [7:0] dataSw;
  logic [5:0] opSw;
  logic       btnA, btnB, btnO;
  logic [7:0] aluResult;
  logic       aluOverflow;
  logic [7:0] dataA, dataB, resultLed;
  logic [5:0] op;
  logic       overflowLed, valid, error;
  logic [2:0] state;

  int testsRun  = 0;
  int testsFail = 0;

  alu_seq_ctrl #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk        (clk),
    .i_reset      (rstN),
    .i_dataSw     (dataSw),
    .i_opSw       (opSw),
    .i_btnA       (btnA),
    .i_btnB       (btnB),
    .i_btnO       (btnO),
    .i_aluResult  (aluResult),
    .i_aluOverflow(aluOverflow),
    .o_dataA      (dataA),
    .o_dataB      (dataB),
    .o_op         (op),
    .o_resultLed  (resultLed),
    .o_overflowLed(overflowLed),
    .o_valid      (valid),
    .o_error      (error),
    .o_state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: only the operations the directed steps use.
  always_comb begin
    aluResult   = 8'h00;
    aluOverflow = 1'b0;
    case (op)
      6'b100000: begin
        aluResult   = dataA + dataB;
        aluOverflow = (dataA[7] == dataB[7]) && (aluResult[7] != dataA[7]);
      end
      6'b100100: aluResult = dataA & dataB;
      default:   aluResult = 8'h00;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clean press: button high for one sampling edge, then released.
  // Returns on the falling edge after the FSM has acted on the press.
  task automatic press(input int which, input logic [7:0] sw, input logic [5:0] opv);
    @(negedge clk);
    dataSw = sw;
    opSw   = opv;
    if (which == 0) btnA = 1'b1;
    if (which == 1) btnB = 1'b1;
    if (which == 2) btnO = 1'b1;
    @(negedge clk);
    btnA = 1'b0;
    btnB = 1'b0;
    btnO = 1'b0;
    @(negedge clk);
  endtask

  task automatic syncReset();
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rstN   = 1'b0;
    dataSw = 8'h00;
    opSw   = 6'b000000;
    btnA   = 1'b0;
    btnB   = 1'b0;
    btnO   = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_state",  32'(state),       32'd0);
    check("rst_dataA",  32'(dataA),       32'h0);
    check("rst_op",     32'(op),          32'h0);
    check("rst_valid",  32'(valid),       32'd0);
    check("rst_error",  32'(error),       32'd0);
    check("rst_result", 32'(resultLed),   32'h0);

    // Basic ADD 5 + 3
    press(0, 8'h05, 6'b000000);
    check("a_state", 32'(state), 32'd1);
    check("a_dataA", 32'(dataA), 32'h05);
    press(1, 8'h03, 6'b000000);
    check("b_state", 32'(state), 32'd2);
    check("b_dataB", 32'(dataB), 32'h03);
    press(2, 8'h00, 6'b100000);
    check("o_state_exec", 32'(state), 32'd3);
    check("o_valid_exec", 32'(valid), 32'd0);
    check("o_op",         32'(op),    32'h20);
    @(negedge clk);
    check("add_state",  32'(state),       32'd4);
    check("add_valid",  32'(valid),       32'd1);
    check("add_result", 32'(resultLed),   32'h08);
    check("add_ovf",    32'(overflowLed), 32'd0);
    check("add_error",  32'(error),       32'd0);

    // Overflowing ADD 0x7F + 0x01, with a B press landing during EXEC
    press(0, 8'h7F, 6'b000000);
    check("ovf_a_valid",  32'(valid),     32'd0);
    check("ovf_a_result", 32'(resultLed), 32'h08);
    press(1, 8'h01, 6'b000000);
    @(negedge clk);
    opSw = 6'b100000;
    btnO = 1'b1;
    @(negedge clk);
    btnO = 1'b0;
    btnB = 1'b1;
    @(negedge clk);
    btnB = 1'b0;
    check("exec_state", 32'(state), 32'd3);
    @(negedge clk);
    check("exec_ign_state", 32'(state),       32'd4);
    check("exec_ign_error", 32'(error),       32'd0);
    check("ovf_result",     32'(resultLed),   32'h80);
    check("ovf_flag",       32'(overflowLed), 32'd1);
    check("ovf_valid",      32'(valid),       32'd1);
    press(0, 8'h11, 6'b000000);
    check("newa_valid",  32'(valid),       32'd0);
    check("newa_result", 32'(resultLed),   32'h80);
    check("newa_ovf",    32'(overflowLed), 32'd1);
    check("newa_state",  32'(state),       32'd1);

    // Out-of-order B in IDLE, then A clears the error
    syncReset();
    press(1, 8'h55, 6'b000000);
    check("idleb_error", 32'(error), 32'd1);
    check("idleb_state", 32'(state), 32'd0);
    check("idleb_dataB", 32'(dataB), 32'h00);
    press(0, 8'h10, 6'b000000);
    check("idlea_error", 32'(error), 32'd0);
    check("idlea_state", 32'(state), 32'd1);

    // Unsupported opcode, then a good one; error stays until the next A
    press(1, 8'h3C, 6'b000000);
    press(2, 8'h00, 6'b111111);
    check("badop_error", 32'(error), 32'd1);
    check("badop_state", 32'(state), 32'd2);
    check("badop_op",    32'(op),    32'h00);
    press(2, 8'h00, 6'b100100);
    check("and_exec", 32'(state), 32'd3);
    @(negedge clk);
    check("and_state",  32'(state),     32'd4);
    check("and_valid",  32'(valid),     32'd1);
    check("and_result", 32'(resultLed), 32'h10);
    check("and_op",     32'(op),        32'h24);
    check("and_error",  32'(error),     32'd1);

    // O press in DONE is an error and does not move the FSM
    press(2, 8'h00, 6'b100000);
    check("done_o_state", 32'(state), 32'd4);
    press(0, 8'h44, 6'b000000);
    check("clr_error", 32'(error), 32'd0);

    // A and B rising together
    @(negedge clk);
    dataSw = 8'h99;
    btnA = 1'b1;
    btnB = 1'b1;
    @(negedge clk);
    btnA = 1'b0;
    btnB = 1'b0;
    @(negedge clk);
    check("coll_error", 32'(error), 32'd1);
    check("coll_state", 32'(state), 32'd1);
    check("coll_dataA", 32'(dataA), 32'h44);
    check("coll_dataB", 32'(dataB), 32'h3C);

    // A held across reset release: no load until released and pressed again
    @(negedge clk);
    dataSw = 8'h77;
    btnA = 1'b1;
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_state", 32'(state), 32'd0);
    check("hold_dataA", 32'(dataA), 32'h00);
    check("hold_error", 32'(error), 32'd0);
    btnA = 1'b0;
    @(negedge clk);
    press(0, 8'h22, 6'b000000);
    check("repress_state", 32'(state), 32'd1);
    check("repress_dataA", 32'(dataA), 32'h22);

    // Asynchronous reset during EXEC
    press(1, 8'h01, 6'b000000);
    press(2, 8'h00, 6'b100000);
    check("pre_rst_exec", 32'(state), 32'd3);
    #2;
    rstN = 1'b0;
    #1;
    check("async_state",  32'(state),       32'd0);
    check("async_dataA",  32'(dataA),       32'h00);
    check("async_dataB",  32'(dataB),       32'h00);
    check("async_op",     32'(op),          32'h00);
    check("async_result", 32'(resultLed),   32'h00);
    check("async_valid",  32'(valid),       32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("post_rst_valid",  32'(valid),     32'd0);
    check("post_rst_result", 32'(resultLed), 32'h00);
    check("post_rst_state",  32'(state),     32'd0);
    press(2, 8'h00, 6'b100000);
    check("post_rst_o_state", 32'(state), 32'd0);
    check("post_rst_o_error", 32'(error), 32'd1);
    check("post_rst_o_valid", 32'(valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
